// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// Holds the MD_* opcode encodings issued by the pipeline and the FSM state
// encodings used by md_unit.
package md_unit_pkg;

  // Opcodes issued to md_unit on its op port
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  // Sequencer FSM states
  localparam logic [0:0] MD_IDLE = 1'b0;
  localparam logic [0:0] MD_RUN  = 1'b1;

endpackage

// File: rtl/md_iter_step.sv
// One radix-2 iteration of the multiply/divide datapath, purely combinational.
//   mul=1: shift-add. {hi,lo} is the partial product with the multiplier
//          draining out of lo; opnd is the multiplicand.
//   mul=0: restoring shift-subtract. hi is the partial remainder, lo shifts
//          the dividend out and the quotient bits in; opnd is the divisor.
module md_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic             mul,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Compute both step flavours and select by the mul flag
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    hi_out  = hi_in;
    lo_out  = lo_in;
    sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opnd} : '0);
    shifted = {hi_in, lo_in[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    if (mul) begin
      hi_out = sum[WIDTH:1];
      lo_out = {sum[0], lo_in[WIDTH-1:1]};
    end else if (shifted >= {1'b0, opnd}) begin
      hi_out = diff[WIDTH-1:0];
      lo_out = {lo_in[WIDTH-2:0], 1'b1};
    end else begin
      hi_out = shifted[WIDTH-1:0];
      lo_out = {lo_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO register pair.
// MULT/MULTU/DIV/DIVU iterate WIDTH cycles on unsigned magnitudes with busy
// high; signs are restored in the final cycle. MTHI/MTLO write in one edge.
// Build option MD_FAST_MUL_EN: MULT/MULTU finish combinationally at the
// accept edge and never raise busy; DIV/DIVU are unaffected.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

`ifdef MD_FAST_MUL_EN
  localparam bit SEQ_MUL = 1'b0;
`else
  localparam bit SEQ_MUL = 1'b1;
`endif

  logic [0:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic             is_mul, neg_q, neg_r, dz;

  logic             idle_start, is_mul_op, is_div_op, is_signed_op, accept;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] step_hi, step_lo, fin_hi, fin_lo;
  logic [2*WIDTH-1:0] prod_mag, prod_signed;

  assign busy = (state == MD_RUN);

  // Decode the issue request and form operand magnitudes
  always_comb begin
    idle_start   = (state == MD_IDLE) && start;
    is_mul_op    = (op == MD_MULT) || (op == MD_MULTU);
    is_div_op    = (op == MD_DIV)  || (op == MD_DIVU);
    is_signed_op = (op == MD_MULT) || (op == MD_DIV);
    mag_a        = (is_signed_op && a[WIDTH-1]) ? -a : a;
    mag_b        = (is_signed_op && b[WIDTH-1]) ? -b : b;
    accept       = idle_start && (is_div_op || (is_mul_op && SEQ_MUL));
  end

  md_iter_step #(.WIDTH(WIDTH)) u_step (
    .mul    (is_mul),
    .hi_in  (acc_hi),
    .lo_in  (acc_lo),
    .opnd   (opnd),
    .hi_out (step_hi),
    .lo_out (step_lo)
  );

  // Sign-correct the last step's output; divide-by-zero forces an all-ones
  // quotient while the remainder path already reproduces the dividend
  always_comb begin
    prod_mag    = {step_hi, step_lo};
    prod_signed = neg_q ? -prod_mag : prod_mag;
    if (is_mul) begin
      {fin_hi, fin_lo} = prod_signed;
    end else begin
      fin_lo = dz ? '1 : (neg_q ? -step_lo : step_lo);
      fin_hi = neg_r ? -step_hi : step_hi;
    end
  end

`ifdef MD_FAST_MUL_EN
  logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;

  // Single-cycle product; the low 2*WIDTH bits of the extended product are
  // the exact two's-complement result for MULT
  always_comb begin
    ext_a     = (op == MD_MULT) ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    ext_b     = (op == MD_MULT) ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    fast_prod = ext_a * ext_b;
  end
`endif

  // FSM, iteration counter, working registers and HI/LO
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      state  <= MD_IDLE;
      count  <= '0;
      hi     <= '0;
      lo     <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      is_mul <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else if (accept) begin
      state  <= MD_RUN;
      count  <= '0;
      acc_hi <= '0;
      acc_lo <= mag_a;
      opnd   <= mag_b;
      is_mul <= is_mul_op;
      neg_q  <= is_signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r  <= is_signed_op && is_div_op && a[WIDTH-1];
      dz     <= is_div_op && (b == '0);
    end else if (idle_start && (op == MD_MTHI)) begin
      hi <= a;
    end else if (idle_start && (op == MD_MTLO)) begin
      lo <= a;
`ifdef MD_FAST_MUL_EN
    end else if (idle_start && is_mul_op) begin
      {hi, lo} <= fast_prod;
`endif
    end else if (state == MD_RUN) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      if (count == CW'(WIDTH - 1)) begin
        hi    <= fin_hi;
        lo    <= fin_lo;
        state <= MD_IDLE;
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit (WIDTH=32). Inputs are driven and
// outputs sampled on the falling clock edge. Multiply latency expectations
// follow MD_FAST_MUL_EN when the bench is built with it.
module tb_md_unit;
  import md_unit_pkg::*;

`ifdef MD_FAST_MUL_EN
  localparam int MUL_CYC = 0;
`else
  localparam int MUL_CYC = 32;
`endif
  localparam int DIV_CYC = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  int cyc;

  md_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; presents one issue strobe for one cycle
  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count falling edges with busy high, bounded so a stuck busy cannot hang
  task automatic wait_done(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // MULT -3 * 7
    issue(MD_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done(cyc);
    check("mult_cycles", cyc, MUL_CYC);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);

    // MULTU same operands, issued in the first idle cycle
    issue(MD_MULTU, 32'hFFFF_FFFD, 32'd7);
    wait_done(cyc);
    check("multu_cycles", cyc, MUL_CYC);
    check("multu_hi", hi, 32'h0000_0006);
    check("multu_lo", lo, 32'hFFFF_FFEB);

    // DIVU 100/7 with an MTLO attempted mid-run
    issue(MD_DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    issue(MD_MTLO, 32'hDEAD_BEEF, 32'd0);
    check("run_busy", {31'd0, busy}, 32'd1);
    check("run_lo_hold", lo, 32'hFFFF_FFEB);
    check("run_hi_hold", hi, 32'h0000_0006);
    wait_done(cyc);
    check("divu_cycles", cyc + 5, DIV_CYC);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    // DIV -7 / 2
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc);
    check("div_neg_cycles", cyc, DIV_CYC);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);

    // DIV 7 / -2
    issue(MD_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_done(cyc);
    check("div_negb_lo", lo, 32'hFFFF_FFFD);
    check("div_negb_hi", hi, 32'd1);

    // Divide by zero, signed and unsigned
    issue(MD_DIV, 32'd5, 32'd0);
    wait_done(cyc);
    check("div0_cycles", cyc, DIV_CYC);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'd5);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd0);
    wait_done(cyc);
    check("div0_neg_lo", lo, 32'hFFFF_FFFF);
    check("div0_neg_hi", hi, 32'hFFFF_FFF9);
    issue(MD_DIVU, 32'h8000_0001, 32'd0);
    wait_done(cyc);
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    check("divu0_hi", hi, 32'h8000_0001);

    // Most-negative / -1 wraps
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'd0);

    // MTHI in idle, single edge
    issue(MD_MTHI, 32'h0000_1234, 32'd0);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_hi", hi, 32'h0000_1234);
    check("mthi_lo", lo, 32'h8000_0000);

    // MTLO in idle
    issue(MD_MTLO, 32'h0BAD_F00D, 32'd0);
    check("mtlo_lo", lo, 32'h0BAD_F00D);
    check("mtlo_hi", hi, 32'h0000_1234);

    // Invalid opcode does nothing
    issue(3'd6, 32'h5555_5555, 32'h3);
    check("inv_busy", {31'd0, busy}, 32'd0);
    check("inv_hi", hi, 32'h0000_1234);
    check("inv_lo", lo, 32'h0BAD_F00D);

    // Reset at iteration 10 of a DIVU aborts it
    issue(MD_DIVU, 32'hFFFF_FFFF, 32'h0001_0000);
    repeat (10) @(negedge clk);
    check("abort_pre_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_done(cyc);
    check("post_abort_cycles", cyc, MUL_CYC);
    check("post_abort_hi", hi, 32'd1);
    check("post_abort_lo", lo, 32'hFFFF_FFFE);

    // DIVU keeps full latency in every build
    issue(MD_DIVU, 32'hFFFF_FFFF, 32'h0001_0000);
    wait_done(cyc);
    check("divu_big_cycles", cyc, DIV_CYC);
    check("divu_big_lo", lo, 32'h0000_FFFF);
    check("divu_big_hi", hi, 32'h0000_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide sequencer for the MIPS core.
- Owns the HI/LO register pair and sequences an iterative shift-add/shift-subtract datapath, which the single-cycle ALU cannot host.
- Sits beside the ALU in EX. The pipeline issues MULT/MULTU/DIV/DIVU/MTHI/MTLO here, reads HI/LO directly for MFHI/MFLO, and stalls on `busy`.

Parameters:
- WIDTH, 32, operand width. Also the number of iterations per multiply/divide.

Ports:
- clk    input   1      system clock, rising edge
- rst    input   1      synchronous, active-high reset
- start  input   1      issue strobe; sampled only when `busy`=0
- op     input   3      MD_* opcode from the shared package
- a      input   WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data
- b      input   WIDTH  rt operand: multiplier or divisor
- busy   output  1      operation in progress; pipeline must stall MD ops and MFHI/MFLO
- hi     output  WIDTH  HI register
- lo     output  WIDTH  LO register

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-high, on ports clk and rst.
  - On rst: busy=0, hi=0, lo=0, FSM to IDLE, iteration counter=0.
  - Reset mid-operation aborts the operation; no partial result is written.
- FSM states: IDLE, RUN.
  - IDLE & start & op∈{MULT,MULTU,DIV,DIVU}: latch operands, go to RUN, count=0, busy=1 from the next cycle.
  - IDLE & start & op=MTHI: hi<=a at that edge. busy stays 0.
  - IDLE & start & op=MTLO: lo<=a at that edge. busy stays 0.
  - RUN: one iteration per cycle. count increments each cycle.
  - RUN, count=WIDTH-1: write hi/lo, go to IDLE, busy<=0 at the same edge.
- Timing:
  - busy is high for exactly WIDTH cycles after the accept edge.
  - New hi/lo are visible in the first cycle busy=0.
  - A back-to-back start is accepted in that same cycle.
- start while busy=1 is ignored entirely, including MTHI/MTLO. hi/lo hold their previous values throughout RUN.
- Invalid op codes are ignored: no state change.
- Unsigned ops:
  - Operands are zero-extended.
  - MULTU: {hi,lo} = a*b, 2*WIDTH-bit product.
  - DIVU: lo = quotient, hi = remainder.
- Signed ops:
  - Operands are converted to magnitude and sign before iterating; results are sign-corrected in the final cycle.
  - MULT: {hi,lo} = two's-complement 64-bit product.
  - DIV: quotient truncates toward zero. Remainder takes the sign of the dividend.
- Division by zero (b=0): no trap. Runs the full WIDTH cycles. Result: lo=all ones, hi=a (unmodified dividend), for both DIV and DIVU.
- DIV with a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0 (wrap, no trap).
- All arithmetic is internal to the block; no dependence on the ALU module.

Optional Feature:
- Macro: MD_FAST_MUL_EN.
- Defined:
  - MULT/MULTU complete combinationally at the accept edge: hi/lo updated at that edge, busy never asserts.
  - DIV/DIVU are unchanged (WIDTH cycles).
- Undefined: all four ops take WIDTH cycles as above.
- MTHI/MTLO, reset and divide-by-zero behaviour are identical in both builds.

Decomposition:
- Shared package (alongside the existing ALU command defines) holds:
  - MD_MULT=3'd0, MD_MULTU=3'd1, MD_DIV=3'd2, MD_DIVU=3'd3, MD_MTHI=3'd4, MD_MTLO=3'd5.
  - FSM state encodings MD_IDLE and MD_RUN.
- One sub-module is natural: md_iter_step. It is a combinational single radix-2 step: shift-add for multiply, restore-subtract for divide. It is selected by a mul/div flag and instantiated once.
- The FSM, counter, sign handling and HI/LO registers stay in md_unit.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 -> busy high 32 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU with the same operands -> hi=0x00000006, lo=0xFFFFFFEB.
- DIVU a=100, b=7 -> lo=14, hi=2. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=5, b=0 -> after 32 cycles lo=0xFFFFFFFF, hi=5. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x1234 in IDLE -> hi=0x1234 next cycle, busy stays 0. MTLO issued while busy -> ignored; lo equals the division result afterwards.
- Start DIVU, assert rst at iteration 10 -> next cycle busy=0, hi=lo=0. A new MULTU issued immediately completes correctly.
- With MD_FAST_MUL_EN: MULTU 0xFFFFFFFF*2 -> busy never 1, next cycle hi=1, lo=0xFFFFFFFE. DIVU still takes 32 cycles.
